// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the two-port data memory arbiter.
// FSM state encoding, owner id type and word geometry.
package dmem_arb_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2
  } state_e;

  typedef logic owner_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner select for two requesters.
// ptr names the port that wins a tie.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  logic   ptr,
  output owner_t grant,
  output logic   valid
);

  assign valid = req0 | req1;

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (req0 && req1): grant = ptr;
      (req1 && !req0): grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/loader arbiter in front of a single data memory.
// Define DMEM_ARB_RR_EN for round-robin; default is port 0 priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [31:0]       wdata0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [31:0]       wdata1_i,
  output logic              ack0_o,
  output logic              err0_o,
  output logic [31:0]       rdata0_o,
  output logic              ack1_o,
  output logic              err1_o,
  output logic [31:0]       rdata1_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LAST_WORD =
    ADDR_W'(MEM_BYTES - WORD_BYTES);

  state_e            state_q;
  owner_t            owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              ptr;
  owner_t            pick_grant;
  logic              pick_valid;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_bad;

  dmem_arb_pick u_pick (
    .req0  (req0_i),
    .req1  (req1_i),
    .ptr   (ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

`ifdef DMEM_ARB_RR_EN
  logic ptr_q;

  // Tie goes to whoever lost the previous grant.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q <= 1'b0;
    end else if (state_q == IDLE && pick_valid) begin
      ptr_q <= ~pick_grant;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  assign sel_we    = pick_grant ? we1_i    : we0_i;
  assign sel_addr  = pick_grant ? addr1_i  : addr0_i;
  assign sel_wdata = pick_grant ? wdata1_i : wdata0_i;
  assign sel_bad   = (|sel_addr[1:0]) ||
                     (sel_addr > LAST_WORD);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_grant;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            state_q <= sel_bad ? ERROR : ACCESS;
          end
        end
        ACCESS:  state_q <= IDLE;
        ERROR:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic        in_acc;
  logic        in_err;
  logic [31:0] rd;

  assign in_acc = (state_q == ACCESS);
  assign in_err = (state_q == ERROR);
  assign busy_o = (state_q != IDLE);

  assign mem_addr_o  = in_acc ? addr_q : '0;
  assign mem_wdata_o = (in_acc && we_q) ? wdata_q : '0;
  assign mem_write_o = in_acc & we_q;
  assign mem_read_o  = in_acc & ~we_q;

  assign rd = (in_acc && !we_q) ? mem_rdata_i : 32'd0;

  assign ack0_o   = busy_o & (owner_q == 1'b0);
  assign ack1_o   = busy_o & (owner_q == 1'b1);
  assign err0_o   = in_err & (owner_q == 1'b0);
  assign err1_o   = in_err & (owner_q == 1'b1);
  assign rdata0_o = (owner_q == 1'b0) ? rd : 32'd0;
  assign rdata1_o = (owner_q == 1'b1) ? rd : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter
// against a transaction-level model with a golden memory image.
module tb_dmem_arbiter;

  localparam int MB = 128;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_i, we0_i, req1_i, we1_i;
  logic [31:0] addr0_i, wdata0_i, addr1_i, wdata1_i;
  logic        ack0_o, err0_o, ack1_o, err1_o;
  logic [31:0] rdata0_o, rdata1_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_read_o, mem_write_o, busy_o;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.ADDR_W(32), .MEM_BYTES(MB)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req0_i      (req0_i),
    .we0_i       (we0_i),
    .addr0_i     (addr0_i),
    .wdata0_i    (wdata0_i),
    .req1_i      (req1_i),
    .we1_i       (we1_i),
    .addr1_i     (addr1_i),
    .wdata1_i    (wdata1_i),
    .ack0_o      (ack0_o),
    .err0_o      (err0_o),
    .rdata0_o    (rdata0_o),
    .ack1_o      (ack1_o),
    .err1_o      (err1_o),
    .rdata1_o    (rdata1_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o)
  );

  function automatic logic [31:0] init_word(int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Attached memory: combinational read, write on the clock edge.
  logic [31:0] mem [32];
  logic [29:0] widx;
  assign widx = mem_addr_o[31:2];
  assign mem_rdata_i = (widx < 30'd32) ? mem[widx[4:0]] : 32'hBAD0_BAD0;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk_i);
      if (mem_write_o && widx < 30'd32) mem[widx[4:0]] = mem_wdata_o;
    end
  end

  bit          active [2];
  bit          hold [2];
  bit          granted [2];
  logic        cwe [2];
  logic [31:0] caddr [2];
  logic [31:0] cwd [2];
  bit          rand_en, rec_en;
  int          seq [$];
  int          exp_seq [4];

  bit          exp_v, exp_err, exp_we;
  int          exp_port, pref;
  logic [31:0] exp_addr, exp_wd;
  logic [31:0] gold [32];
  logic [31:0] last_rd [2];
  logic        last_err [2];

  int n_chk, n_err;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic issue(int p, logic we, logic [31:0] a, logic [31:0] d);
    active[p]  = 1'b1;
    granted[p] = 1'b0;
    cwe[p]     = we;
    caddr[p]   = a;
    cwd[p]     = d;
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 7);
    if (k < 6) return 32'($urandom_range(0, 31)) << 2;
    if (k == 6)
      return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
    return 32'($urandom_range(MB, 4096)) & ~32'd3;
  endfunction

  task automatic rand_drive();
    for (int p = 0; p < 2; p++) begin
      if (!active[p]) begin
        if ($urandom_range(0, 2) == 0)
          issue(p, 1'($urandom), rand_addr(), $urandom);
      end else if (!granted[p] && $urandom_range(0, 15) == 0) begin
        active[p] = 1'b0;
      end
    end
  endtask

  // Once registered, the command is scrambled to show it is ignored.
  task automatic drive_ports();
    req0_i = active[0]; we0_i = cwe[0];
    addr0_i = caddr[0]; wdata0_i = cwd[0];
    req1_i = active[1]; we1_i = cwe[1];
    addr1_i = caddr[1]; wdata1_i = cwd[1];
    if (rand_en && granted[0]) begin
      we0_i = 1'($urandom); addr0_i = $urandom; wdata0_i = $urandom;
    end
    if (rand_en && granted[1]) begin
      we1_i = 1'($urandom); addr1_i = $urandom; wdata1_i = $urandom;
    end
  endtask

  // A grant is a one-cycle response; arbitration only after idle.
  task automatic model_step();
    int w;
    if (exp_v) begin
      exp_v = 1'b0;
      return;
    end
    if (!active[0] && !active[1]) return;
    w = (active[0] && active[1]) ? pref : (active[0] ? 0 : 1);
    exp_v    = 1'b1;
    exp_port = w;
    exp_we   = cwe[w];
    exp_addr = caddr[w];
    exp_wd   = cwd[w];
    exp_err  = (exp_addr % 4 != 0) || (exp_addr > MB - 4);
    granted[w] = 1'b1;
`ifdef DMEM_ARB_RR_EN
    pref = 1 - w;
`endif
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      active[p] = 1'b0; hold[p] = 1'b0; granted[p] = 1'b0;
    end
    exp_v = 1'b0;
    pref  = 0;
  endtask

  task automatic step();
    logic [6:0]  ectl;
    logic [31:0] erd;
    @(negedge clk_i);
    ectl = {exp_v && exp_port == 0, exp_v && exp_port == 1,
            exp_v && exp_err && exp_port == 0,
            exp_v && exp_err && exp_port == 1,
            exp_v && !exp_err && !exp_we,
            exp_v && !exp_err && exp_we, exp_v};
    check("ctl", 64'({ack0_o, ack1_o, err0_o, err1_o,
                      mem_read_o, mem_write_o, busy_o}), 64'(ectl));
    erd = (exp_v && !exp_err && !exp_we) ? gold[exp_addr[6:2]] : 32'd0;
    check("rdata0", 64'(rdata0_o), 64'(exp_port == 0 ? erd : 32'd0));
    check("rdata1", 64'(rdata1_o), 64'(exp_port == 1 ? erd : 32'd0));
    if (exp_v && !exp_err) begin
      check("maddr", 64'(mem_addr_o), 64'(exp_addr));
      if (exp_we) check("mwdata", 64'(mem_wdata_o), 64'(exp_wd));
    end
    if (rec_en) begin
      if (ack0_o) seq.push_back(0);
      if (ack1_o) seq.push_back(1);
    end
    if (exp_v) begin
      last_rd[exp_port]  = exp_port == 1 ? rdata1_o : rdata0_o;
      last_err[exp_port] = exp_port == 1 ? err1_o : err0_o;
      if (!exp_err && exp_we) gold[exp_addr[6:2]] = exp_wd;
      granted[exp_port] = 1'b0;
      if (!hold[exp_port]) active[exp_port] = 1'b0;
    end
    if (rand_en) rand_drive();
    drive_ports();
    model_step();
  endtask

  task automatic wait_done(int p, string tag);
    int n;
    n = 0;
    while (active[p] && n < 20) begin
      step();
      n++;
    end
    check(tag, 64'(active[p]), 64'(0));
  endtask

  task automatic do_release();
    @(negedge clk_i);
    rst_i = 1'b1;
    drive_ports();
    model_step();
  endtask

  initial begin
    int n, ones;
    n_chk = 0; n_err = 0;
    rst_i = 1'b0;
    rand_en = 1'b0; rec_en = 1'b0;
    for (int i = 0; i < 32; i++) gold[i] = init_word(i);
    for (int p = 0; p < 2; p++) begin
      cwe[p] = 1'b0; caddr[p] = '0; cwd[p] = '0;
    end
    model_reset();
    drive_ports();
    #1;
    check("rst_ctl", 64'({ack0_o, ack1_o, err0_o, err1_o,
                          mem_read_o, mem_write_o, busy_o}), 64'(0));
    check("rst_rd", {rdata0_o, rdata1_o}, 64'(0));
    check("rst_mem", {mem_addr_o, mem_wdata_o}, 64'(0));

    // Both ports held from reset release.
`ifdef DMEM_ARB_RR_EN
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
`else
    exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0;
`endif
    issue(0, 1'b0, 32'h00, 32'h0);
    issue(1, 1'b0, 32'h04, 32'h0);
    hold[0] = 1'b1; hold[1] = 1'b1;
    rec_en = 1'b1;
    do_release();
    repeat (8) step();
    rec_en = 1'b0;
    check("seq_len", 64'(seq.size() >= 4), 64'(1));
    for (int i = 0; i < 4; i++)
      check("seq", 64'(i < seq.size() ? seq[i] : 9), 64'(exp_seq[i]));
    hold[0] = 1'b0;
    wait_done(0, "p0_drop");
    hold[1] = 1'b0;
    wait_done(1, "p1_after");

    // Write then read back.
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    wait_done(0, "w10");
    issue(0, 1'b0, 32'h10, 32'h0);
    wait_done(0, "r10");
    check("r10_data", 64'(last_rd[0]), 64'(32'hDEAD_BEEF));

    // Misaligned, out of range, and last legal word.
    issue(1, 1'b0, 32'h06, 32'h0);
    wait_done(1, "e06");
    check("e06_err", 64'(last_err[1]), 64'(1));
    check("e06_rd", 64'(last_rd[1]), 64'(0));
    issue(1, 1'b0, 32'h80, 32'h0);
    wait_done(1, "e80");
    check("e80_err", 64'(last_err[1]), 64'(1));
    check("e80_rd", 64'(last_rd[1]), 64'(0));
    issue(1, 1'b0, 32'h7C, 32'h0);
    wait_done(1, "r7c");
    check("r7c_err", 64'(last_err[1]), 64'(0));
    check("r7c_rd", 64'(last_rd[1]), 64'(init_word(31)));

    // Port 1 request withdrawn while port 0 is served.
    seq.delete();
    rec_en = 1'b1;
    issue(0, 1'b0, 32'h08, 32'h0);
    step();
    issue(1, 1'b0, 32'h0C, 32'h0);
    step();
    active[1] = 1'b0;
    repeat (4) step();
    rec_en = 1'b0;
    ones = 0;
    foreach (seq[i]) if (seq[i] == 1) ones++;
    check("no_ack1", 64'(ones), 64'(0));
    check("ack0_once", 64'(seq.size()), 64'(1));

    // Reset in the middle of a write.
    issue(0, 1'b1, 32'h20, 32'h1234_5678);
    step();
    @(posedge clk_i);
    #2;
    check("pre_rst_mw", 64'(mem_write_o), 64'(1));
    rst_i = 1'b0;
    #1;
    check("rst_mw", 64'(mem_write_o), 64'(0));
    check("rst_ack", 64'(ack0_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    model_reset();
    drive_ports();
    do_release();
    repeat (2) step();
    issue(0, 1'b0, 32'h20, 32'h0);
    wait_done(0, "r20");
    check("rst_nowr", 64'(last_rd[0]), 64'(init_word(8)));

    // Random traffic.
    rand_en = 1'b1;
    repeat (1500) step();
    rand_en = 1'b0;
    n = 0;
    while ((active[0] || active[1]) && n < 50) begin
      step();
      n++;
    end
    check("drain", 64'(active[0] | active[1]), 64'(0));
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
